// File: rtl/hs_mul_driver.sv
// hs_mul_driver: stimulus and capture engine for the high-speed multiplier
// test macro. It accepts an operand pair, shifts both operands MSB-first into
// the macro on a generated shift clock, pulses the latch gate, then reads the
// 26-bit product back over the two byte buses in two select phases and offers
// it on an output valid/ready handshake. Every output comes straight from a
// flop.
//
// Optional feature: define HS_MUL_CHECK_EN to add the out_mismatch port and
// an on-chip reference multiplier that flags a wrong captured product.

module hs_mul_driver #(
    parameter int SCLK_DIV = 2,
    parameter int SETTLE   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        sclk,
    output logic        sdata_a,
    output logic        sdata_b,
    output logic        latch,
    output logic [1:0]  sel,
    input  logic [7:0]  rd_lo,
    input  logic [7:0]  rd_hi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] out_product
`ifdef HS_MUL_CHECK_EN
    ,
    output logic        out_mismatch
`endif
);

    // One shared down-the-phase counter covers the sclk half-period, the
    // latch pulse and both settle windows, so it is sized for the largest.
    localparam int CNT_MAX = (SCLK_DIV > SETTLE) ? SCLK_DIV : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DIV_LAST    = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_SET_LO,
        S_SET_HI,
        S_DONE
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [3:0]     bit_cnt, bit_cnt_n;
    logic [15:0]    sh_a, sh_a_n;
    logic [15:0]    sh_b, sh_b_n;
    logic           sclk_n;
    logic           latch_n;
    logic [1:0]     sel_n;
    logic           in_ready_n;
    logic           out_valid_n;
    logic [25:0]    product_n;

    // The serial lines are the MSB of each shift register; they only move
    // when the register is loaded (sclk low) or shifted on a falling edge.
    assign sdata_a = sh_a[15];
    assign sdata_b = sh_b[15];

`ifdef HS_MUL_CHECK_EN
    logic [12:0] op_a, op_b;
    logic [25:0] expected;
    logic        mismatch_n;

    assign expected = {13'd0, op_a} * {13'd0, op_b};

    // Operand copies for the reference product; the shift registers are
    // consumed during SHIFT so they cannot serve this purpose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a         <= '0;
            op_b         <= '0;
            out_mismatch <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid && in_ready) begin
                op_a <= in_a[12:0];
                op_b <= in_b[12:0];
            end
            out_mismatch <= mismatch_n;
        end
    end
`endif

    // State register plus all registered outputs and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            sclk        <= 1'b0;
            latch       <= 1'b0;
            sel         <= 2'b00;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_cnt_n;
            sh_a        <= sh_a_n;
            sh_b        <= sh_b_n;
            sclk        <= sclk_n;
            latch       <= latch_n;
            sel         <= sel_n;
            in_ready    <= in_ready_n;
            out_valid   <= out_valid_n;
            out_product <= product_n;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so that the
    // registered copies carry the value that belongs to the state entered.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_cnt_n   = bit_cnt;
        sh_a_n      = sh_a;
        sh_b_n      = sh_b;
        sclk_n      = sclk;
        latch_n     = 1'b0;
        sel_n       = 2'b00;
        out_valid_n = out_valid;
        product_n   = out_product;
`ifdef HS_MUL_CHECK_EN
        mismatch_n  = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    state_n   = S_SHIFT;
                    sh_a_n    = in_a;
                    sh_b_n    = in_b;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    sclk_n    = 1'b0;
                end
            end

            S_SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        // Falling edge: present the next bit and count the
                        // one just clocked in by the preceding rising edge.
                        sclk_n    = 1'b0;
                        sh_a_n    = {sh_a[14:0], 1'b0};
                        sh_b_n    = {sh_b[14:0], 1'b0};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state_n = S_LATCH;
                            latch_n = 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            S_LATCH: begin
                latch_n = 1'b1;
                if (cnt == DIV_LAST) begin
                    cnt_n   = '0;
                    latch_n = 1'b0;
                    state_n = S_SET_LO;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            S_SET_LO: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_n           = '0;
                    product_n[15:0] = {rd_hi, rd_lo};
                    state_n         = S_SET_HI;
                    sel_n           = 2'b10;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            S_SET_HI: begin
                sel_n = 2'b10;
                if (cnt == SETTLE_LAST) begin
                    cnt_n            = '0;
                    product_n[25:16] = {rd_hi[1:0], rd_lo};
                    state_n          = S_DONE;
                    sel_n            = 2'b00;
                    out_valid_n      = 1'b1;
`ifdef HS_MUL_CHECK_EN
                    mismatch_n       = (product_n != expected);
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            S_DONE: begin
                if (out_valid && out_ready) begin
                    state_n     = S_IDLE;
                    out_valid_n = 1'b0;
                end
`ifdef HS_MUL_CHECK_EN
                else begin
                    mismatch_n = out_mismatch;
                end
`endif
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        in_ready_n = (state_n == S_IDLE);
    end

endmodule

// File: tb/tb_hs_mul_driver.sv
// Directed bench for hs_mul_driver with a behavioural model of the multiplier
// macro (serial shift registers, transparent latch, select mux on the byte
// buses). Expected products are hand-computed constants.

module tb_hs_mul_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        sclk, sdata_a, sdata_b, latch;
    logic [1:0]  sel;
    logic [7:0]  rd_lo = 8'h00, rd_hi = 8'h00;
    logic        out_valid, out_ready;
    logic [25:0] out_product;
`ifdef HS_MUL_CHECK_EN
    logic        out_mismatch;
    logic        mm_seen;
`endif

    hs_mul_driver #(.SCLK_DIV(2), .SETTLE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .sclk        (sclk),
        .sdata_a     (sdata_a),
        .sdata_b     (sdata_b),
        .latch       (latch),
        .sel         (sel),
        .rd_lo       (rd_lo),
        .rd_hi       (rd_hi),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
`ifdef HS_MUL_CHECK_EN
        ,
        .out_mismatch(out_mismatch)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Macro model
    logic [15:0] ma = '0, mb = '0, la = '0, lb = '0;
    logic [25:0] mprod;
    logic        corrupt = 1'b0;
    assign mprod = {13'd0, la[12:0]} * {13'd0, lb[12:0]};

    int sclk_rises = 0;
    always @(posedge sclk) begin
        ma <= {ma[14:0], sdata_a};
        mb <= {mb[14:0], sdata_b};
        sclk_rises <= sclk_rises + 1;
    end

    always @(posedge clk) begin
        if (latch) begin
            la <= ma;
            lb <= mb;
        end
    end

    // Output mux with one cycle of settling; junk in rd_hi[7:2] for the high phase.
    always @(posedge clk) begin
        case (sel)
            2'b00: begin
                rd_lo <= mprod[7:0] ^ {7'd0, corrupt};
                rd_hi <= mprod[15:8];
            end
            2'b10: begin
                rd_lo <= mprod[23:16];
                rd_hi <= {6'b101101, mprod[25:24]};
            end
            2'b01:   {rd_hi, rd_lo} <= la;
            default: {rd_hi, rd_lo} <= lb;
        endcase
    end

    // Cycle counter and handshake/event monitors
    int cyc = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;
    int ov_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
        if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
        if (!rst && out_valid) ov_cnt <= ov_cnt + 1;
    end

    int   latch_hi = 0;
    int   bad_sel  = 0;
    int   sd_viol  = 0;
    logic pa = 1'b0, pb = 1'b0;
    always @(negedge clk) begin
        if (latch) latch_hi++;
        if (sel[0]) bad_sel++;
        if ((sdata_a !== pa || sdata_b !== pb) && sclk) sd_viol++;
        pa = sdata_a;
        pb = sdata_b;
    end

    int stab_err = 0;

    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int hold,
                           input bit busy_poke, output logic [25:0] prod, output int lat);
        int acc_cyc;
        int n;
        prod = '0;
        lat  = -1;
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        if (busy_poke) begin
            in_valid = 1'b1;
            in_a     = 16'h0777;
            in_b     = 16'h0333;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 300);
        in_valid = 1'b0;
        if (!out_valid) begin
            check("timeout_out_valid", 32'd0, 32'd1);
            out_ready = 1'b0;
            return;
        end
        lat  = cyc - acc_cyc;
        prod = out_product;
`ifdef HS_MUL_CHECK_EN
        mm_seen = out_mismatch;
`endif
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                if (out_product !== prod || !out_valid || in_ready) stab_err++;
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("ov_drop_after_accept", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    endtask

    logic [25:0] prod;
    int          lat;
    int          r0, l0, a0, h0, o0, n;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        r0  = sclk_rises;
        repeat (10) @(negedge clk);

        // Reset / idle state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_sdata", {30'd0, sdata_a, sdata_b}, 32'd0);
        check("rst_latch", {31'd0, latch}, 32'd0);
        check("rst_sel", {30'd0, sel}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_product", {6'd0, out_product}, 32'd0);
        check("idle_sclk_static", sclk_rises - r0, 32'd0);

        // 0x1234 * 0x0056 = 4660 * 86 = 400760
        r0 = sclk_rises;
        l0 = latch_hi;
        run_txn(16'h1234, 16'h0056, 0, 1'b0, prod, lat);
        check("t1_latency", lat, 32'd74);
        check("t1_product", {6'd0, prod}, 32'h0061D78);
        check("t1_sclk_rises", sclk_rises - r0, 32'd16);
        check("t1_serial_a", {16'd0, ma}, 32'h1234);
        check("t1_serial_b", {16'd0, mb}, 32'h0056);
        check("t1_latch_cycles", latch_hi - l0, 32'd2);

        // 0x1FFF * 0x1FFF = 8191^2 = 67092481
        run_txn(16'h1FFF, 16'h1FFF, 0, 1'b0, prod, lat);
        check("t2_product", {6'd0, prod}, 32'h3FFC001);
        check("t2_bits_25_24", {30'd0, prod[25:24]}, 32'd3);

        // Back-pressure with in_valid offered while busy: 0xABC * 0x11 = 46716
        a0 = acc_cnt;
        h0 = hs_cnt;
        stab_err = 0;
        run_txn(16'h0ABC, 16'h0011, 20, 1'b1, prod, lat);
        repeat (5) @(negedge clk);
        check("t3_product", {6'd0, prod}, 32'h000B67C);
        check("t3_stable", stab_err, 32'd0);
        check("t3_accepts", acc_cnt - a0, 32'd1);
        check("t3_handshakes", hs_cnt - h0, 32'd1);

        // Reset in the middle of SHIFT
        @(negedge clk);
        in_a     = 16'h0F0F;
        in_b     = 16'h00F0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        r0 = sclk_rises;
        n  = 0;
        while (sclk_rises - r0 < 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_bit7", {31'd0, (sclk_rises - r0 >= 8)}, 32'd1);
        rst = 1'b1;
        #1;
        check("t4_async_sclk", {31'd0, sclk}, 32'd0);
        check("t4_async_in_ready", {31'd0, in_ready}, 32'd1);
        check("t4_async_sdata", {30'd0, sdata_a, sdata_b}, 32'd0);
        o0 = ov_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("t4_no_stale_valid", ov_cnt - o0, 32'd0);
        run_txn(16'h0003, 16'h0005, 0, 1'b0, prod, lat);
        check("t4_product", {6'd0, prod}, 32'd15);
        check("t4_latency", lat, 32'd74);

`ifdef HS_MUL_CHECK_EN
        corrupt = 1'b1;
        run_txn(16'h1234, 16'h0056, 0, 1'b0, prod, lat);
        check("t5_bad_product", {6'd0, prod}, 32'h0061D79);
        check("t5_mismatch_set", {31'd0, mm_seen}, 32'd1);
        corrupt = 1'b0;
        run_txn(16'h1234, 16'h0056, 0, 1'b0, prod, lat);
        check("t5_mismatch_clear", {31'd0, mm_seen}, 32'd0);
`endif

        check("never_sel_echo", bad_sel, 32'd0);
        check("sdata_only_sclk_low", sd_viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_mul_driver.md
# hs_mul_driver

Synchronous stimulus and capture engine for the high-speed multiplier test macro. Takes a 16-bit operand pair over a valid/ready handshake and shifts both operands serially into the macro's two input shift registers on a generated shift clock. It then pulses the latch gate, selects and reads back the 26-bit product over the two byte buses, and returns it over a second valid/ready handshake. It sits on the test-harness side of the multiplier pins and drives the lines the macro samples on `ui_in`.

## Interface
- `SCLK_DIV`, 2: half-period of `sclk` in `clk` cycles; must be ≥1.
- `SETTLE`, 4: `clk` cycles allowed for multiplier and output mux to settle before each byte-pair capture; must be ≥1.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: high only in IDLE.
- `in_a` in 16: operand A; sampled on the accepting edge.
- `in_b` in 16: operand B; sampled on the accepting edge.
- `sclk` out 1: shift clock to the macro.
- `sdata_a` out 1: serial A, MSB first.
- `sdata_b` out 1: serial B, MSB first.
- `latch` out 1: latch gate; active high, transparent while high.
- `sel` out 2: output select. `sel[0]` = macro bit 5, `sel[1]` = macro bit 6.
- `rd_lo` in 8: macro low output byte.
- `rd_hi` in 8: macro high output byte.
- `out_valid` out 1: product available.
- `out_ready` in 1: consumer accepts.
- `out_product` out 26: captured product.

## Operation
- States and transitions:
  - IDLE → SHIFT on `in_valid && in_ready`. Operands are copied into internal 16-bit shift registers.
  - SHIFT → LATCH after the 16th `sclk` falling edge.
  - LATCH → SET_LO after `SCLK_DIV` cycles.
  - SET_LO → SET_HI after `SETTLE` cycles.
  - SET_HI → DONE after `SETTLE` cycles.
  - DONE → IDLE on `out_valid && out_ready`.
- SHIFT:
  - Each bit occupies one `sclk` period: `SCLK_DIV` cycles low, then `SCLK_DIV` cycles high.
  - `sdata_a`/`sdata_b` change only while `sclk` is low: at state entry, and together with each `sclk` falling edge.
  - Exactly 16 rising edges are produced. Bit 15 is presented first, so after 16 shifts the macro register holds the operand unreversed.
  - `sclk` returns low and stays low after the last bit.
- LATCH: `latch`=1 for `SCLK_DIV` cycles; `sclk` is held low. `latch` is 0 in all other states.
- SET_LO:
  - `sel`=2'b00.
  - On the final cycle, capture `out_product[15:0]` = {`rd_hi`, `rd_lo`}.
- SET_HI:
  - `sel`=2'b10.
  - On the final cycle, capture `out_product[25:16]` = {`rd_hi[1:0]`, `rd_lo`}.
  - `rd_hi[7:2]` is ignored.
- DONE:
  - `out_valid`=1; `out_product` is held stable until accepted.
  - `sel` returns to 2'b00.
- The macro multiplies only bits [12:0] of each operand, but all 16 bits are shifted regardless.
- `sel` values 2'b01 and 2'b11 (operand echo) are never driven.

## Timing
- Reset values, applied asynchronously while `rst`=1:
  - State IDLE.
  - `in_ready`=1.
  - `sclk`, `sdata_a`, `sdata_b`, `latch`=0; `sel`=2'b00.
  - `out_valid`=0; `out_product`=0.
  - Internal counters cleared.
- Latency: `out_valid` rises 33·`SCLK_DIV` + 2·`SETTLE` cycles after the accepting edge. With defaults this is 74 cycles.
- All outputs are registered; there is no combinational path from `rd_lo`/`rd_hi` to any output.
- `in_valid` while busy: ignored; `in_ready`=0 and no operand is sampled.
- Acceptance in DONE: if `out_ready` is held high on entry, `out_valid` lasts exactly one cycle. IDLE, with `in_ready`=1, follows on the next cycle; there is no same-cycle re-accept.
- `rst` asserted mid-SHIFT or mid-LATCH:
  - Immediate return to reset values and the in-flight pair is dropped.
  - The macro's shift registers are left partially loaded; the next transaction fully overwrites them.
- Back-pressure: DONE holds indefinitely while `out_ready`=0.

## Configuration
- `HS_MUL_CHECK_EN` defined:
  - Adds output `out_mismatch` (1 bit, reset 0).
  - The block computes the expected product `in_a[12:0]*in_b[12:0]` from the latched operands; a sequential or combinational multiplier is allowed, provided the value is ready by DONE.
  - `out_mismatch` = (expected ≠ `out_product`), valid with `out_valid` and 0 otherwise.
- `HS_MUL_CHECK_EN` undefined: no checker logic and no `out_mismatch` port.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values; `in_ready`=1; `sclk` static low.
- A=0x1234, B=0x0056, model returns `in_a[12:0]*in_b[12:0]` after `SETTLE`:
  - Serial streams carry exactly 16 `sclk` rising edges, MSB first.
  - `latch` is high for 2 cycles.
  - `out_product`=0x061D78 at cycle 74.
- A=0x1FFF, B=0x1FFF → `out_product`=0x3FFC001; bits [25:24] are captured from `rd_hi[1:0]`.
- Hold `out_ready`=0 for 20 cycles in DONE, and offer `in_valid` during the busy period:
  - `out_product` is stable throughout.
  - No second operand pair is accepted.
  - Exactly one transaction completes when `out_ready` rises.
- Assert `rst` at bit 7 of SHIFT, then send A=3, B=5 → the aborted pair never produces `out_valid`; the next result is 15.
- With `HS_MUL_CHECK_EN`, the model corrupts `rd_lo` bit 0 → `out_mismatch`=1 alongside `out_valid`; with the correct value, `out_mismatch`=0.
